complex_nr_acc: RTL and testbench

COMPLEX_NR_ACC -- requirements
Module: complex_nr_acc

---
 rtl/complex_nr_acc_if.sv | 28 ++
 rtl/complex_nr_acc.sv | 95 +++++++++
 tb/tb_complex_nr_acc.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_nr_acc_if.sv
// Handshake bundle for the complex product accumulator:
// product input channel, flush request and sum output channel.
interface complex_nr_acc_if #(
    parameter int RES_WIDTH = 18,
    parameter int ACC_WIDTH = 20,
    parameter int CNT_WIDTH = 4
);
    logic                        res_val;
    logic                        res_ready;
    logic signed [RES_WIDTH-1:0] res_re;
    logic signed [RES_WIDTH-1:0] res_im;
    logic                        flush;
    logic                        acc_val;
    logic                        acc_ready;
    logic signed [ACC_WIDTH-1:0] acc_re;
    logic signed [ACC_WIDTH-1:0] acc_im;
    logic [CNT_WIDTH-1:0]        acc_cnt;

    modport master (
        output res_val, res_re, res_im, flush, acc_ready,
        input  res_ready, acc_val, acc_re, acc_im, acc_cnt
    );

    modport slave (
        input  res_val, res_re, res_im, flush, acc_ready,
        output res_ready, acc_val, acc_re, acc_im, acc_cnt
    );
endinterface

// File: rtl/complex_nr_acc.sv
// Complex product accumulator: sums ACC_LEN products (or fewer on flush)
// and presents the sum on a valid/ready output channel.
module complex_nr_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 2*DATA_WIDTH+2,
    parameter int ACC_LEN    = 4,
    parameter int CNT_WIDTH  = 4,
    parameter int ACC_WIDTH  = RES_WIDTH+2
) (
    input logic              clk,
    input logic              sw_rst,
    complex_nr_acc_if.slave  bus
);
    if (ACC_LEN < 1 || ACC_LEN > (2**CNT_WIDTH)-1) begin : g_bad_len
        $error("complex_nr_acc: ACC_LEN out of range");
    end
    if (ACC_WIDTH < RES_WIDTH + $clog2(ACC_LEN)) begin : g_bad_acc
        $error("complex_nr_acc: ACC_WIDTH too small");
    end
    if (RES_WIDTH < 2*DATA_WIDTH) begin : g_bad_res
        $error("complex_nr_acc: RES_WIDTH too small");
    end

    typedef enum logic {ACCUM, OUTPUT} state_t;

    localparam logic [CNT_WIDTH-1:0] LEN = CNT_WIDTH'(ACC_LEN);

    state_t                      state;
    logic                        res_ready_q;
    logic                        acc_val_q;
    logic signed [ACC_WIDTH-1:0] re_q;
    logic signed [ACC_WIDTH-1:0] im_q;
    logic [CNT_WIDTH-1:0]        cnt_q;

    logic                        accept;
    logic                        go_out;
    logic [CNT_WIDTH-1:0]        cnt_nxt;
    logic signed [ACC_WIDTH-1:0] re_ext;
    logic signed [ACC_WIDTH-1:0] im_ext;

    assign re_ext  = {{(ACC_WIDTH-RES_WIDTH){bus.res_re[RES_WIDTH-1]}}, bus.res_re};
    assign im_ext  = {{(ACC_WIDTH-RES_WIDTH){bus.res_im[RES_WIDTH-1]}}, bus.res_im};
    assign accept  = bus.res_val && res_ready_q;
    assign cnt_nxt = cnt_q + CNT_WIDTH'(accept);

    // Flush only counts when the sum will hold at least one product.
    assign go_out = (state == ACCUM) &&
                    ((accept && cnt_nxt == LEN) ||
                     (bus.flush && (cnt_q != '0 || accept)));

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state       <= ACCUM;
            res_ready_q <= 1'b0;
            acc_val_q   <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        re_q  <= re_q + re_ext;
                        im_q  <= im_q + im_ext;
                        cnt_q <= cnt_nxt;
                    end
                    if (go_out) begin
                        state       <= OUTPUT;
                        acc_val_q   <= 1'b1;
                        res_ready_q <= 1'b0;
                    end else begin
                        res_ready_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.acc_ready) begin
                        state       <= ACCUM;
                        acc_val_q   <= 1'b0;
                        res_ready_q <= 1'b1;
                        re_q        <= '0;
                        im_q        <= '0;
                        cnt_q       <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.res_ready = res_ready_q;
    assign bus.acc_val   = acc_val_q;
    assign bus.acc_re    = re_q;
    assign bus.acc_im    = im_q;
    assign bus.acc_cnt   = cnt_q;
endmodule

// File: tb/tb_complex_nr_acc.sv
// Directed bench for complex_nr_acc with default parameters
// (RES_WIDTH=18, ACC_WIDTH=20, ACC_LEN=4).
module tb_complex_nr_acc;
    logic clk;
    logic sw_rst;
    int   errors;
    int   checks;

    complex_nr_acc_if #(.RES_WIDTH(18), .ACC_WIDTH(20), .CNT_WIDTH(4)) bus ();

    complex_nr_acc dut (
        .clk    (clk),
        .sw_rst (sw_rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im);
        bus.res_re  = 18'(re);
        bus.res_im  = 18'(im);
        bus.res_val = 1'b1;
        for (int i = 0; i < 20 && bus.res_ready !== 1'b1; i++) tick();
        checks++;
        if (bus.res_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: res_ready=%0b want 1", bus.res_ready);
        end
        tick();
        bus.res_val = 1'b0;
    endtask

    task automatic test_reset();
        sw_rst = 1'b1;
        tick();
        checks++;
        if (bus.acc_val !== 1'b0 || bus.res_ready !== 1'b0 || bus.acc_re !== 20'd0 ||
            bus.acc_im !== 20'd0 || bus.acc_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got val=%0b rdy=%0b re=%0d im=%0d cnt=%0d want all 0",
                     bus.acc_val, bus.res_ready, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        sw_rst = 1'b0;
        tick();
        checks++;
        if (bus.res_ready !== 1'b1 || bus.acc_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%0b val=%0b want rdy=1 val=0",
                     bus.res_ready, bus.acc_val);
        end
    endtask

    task automatic test_basic();
        bus.acc_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(2, 16);
        checks++;
        if (bus.acc_val !== 1'b0 || bus.acc_cnt !== 4'd3 || bus.acc_re !== 20'd6 ||
            bus.acc_im !== 20'd48) begin
            errors++;
            $display("FAIL basic_partial: got val=%0b cnt=%0d re=%0d im=%0d want val=0 cnt=3 re=6 im=48",
                     bus.acc_val, bus.acc_cnt, bus.acc_re, bus.acc_im);
        end
        send(2, 16);
        checks++;
        if (bus.acc_val !== 1'b1 || bus.res_ready !== 1'b0 || bus.acc_re !== 20'd8 ||
            bus.acc_im !== 20'd64 || bus.acc_cnt !== 4'd4) begin
            errors++;
            $display("FAIL basic_sum: got val=%0b rdy=%0b re=%0d im=%0d cnt=%0d want val=1 rdy=0 re=8 im=64 cnt=4",
                     bus.acc_val, bus.res_ready, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        tick();
        checks++;
        if (bus.acc_val !== 1'b0 || bus.res_ready !== 1'b1 || bus.acc_re !== 20'd0 ||
            bus.acc_im !== 20'd0 || bus.acc_cnt !== 4'd0) begin
            errors++;
            $display("FAIL basic_clear: got val=%0b rdy=%0b re=%0d im=%0d cnt=%0d want val=0 rdy=1 re=0 im=0 cnt=0",
                     bus.acc_val, bus.res_ready, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        bus.acc_ready = 1'b0;
    endtask

    task automatic test_corner();
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 130050);
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_re !== 20'd0 || bus.acc_im !== 20'd520200 ||
            bus.acc_cnt !== 4'd4) begin
            errors++;
            $display("FAIL corner_pos: got val=%0b re=%0d im=%0d cnt=%0d want val=1 re=0 im=520200 cnt=4",
                     bus.acc_val, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(-65025, 0);
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_re !== 20'(-260100) || bus.acc_im !== 20'd0 ||
            bus.acc_cnt !== 4'd4) begin
            errors++;
            $display("FAIL corner_neg: got val=%0b re=%0d im=%0d cnt=%0d want val=1 re=-260100 im=0 cnt=4",
                     bus.acc_val, $signed(bus.acc_re), bus.acc_im, bus.acc_cnt);
        end
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 1);
        bus.res_re  = 18'd5;
        bus.res_im  = 18'd5;
        bus.res_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.acc_val !== 1'b1 || bus.res_ready !== 1'b0 || bus.acc_re !== 20'd4 ||
                bus.acc_im !== 20'd4 || bus.acc_cnt !== 4'd4) begin
                errors++;
                $display("FAIL bp_hold%0d: got val=%0b rdy=%0b re=%0d im=%0d cnt=%0d want val=1 rdy=0 re=4 im=4 cnt=4",
                         i, bus.acc_val, bus.res_ready, bus.acc_re, bus.acc_im, bus.acc_cnt);
            end
            tick();
        end
        bus.acc_ready = 1'b1;
        tick();
        checks++;
        if (bus.acc_val !== 1'b0 || bus.res_ready !== 1'b1 || bus.acc_cnt !== 4'd0 ||
            bus.acc_re !== 20'd0) begin
            errors++;
            $display("FAIL bp_release: got val=%0b rdy=%0b cnt=%0d re=%0d want val=0 rdy=1 cnt=0 re=0",
                     bus.acc_val, bus.res_ready, bus.acc_cnt, bus.acc_re);
        end
        tick();
        bus.res_val = 1'b0;
        checks++;
        if (bus.acc_cnt !== 4'd1 || bus.acc_re !== 20'd5 || bus.acc_im !== 20'd5) begin
            errors++;
            $display("FAIL bp_held_accept: got cnt=%0d re=%0d im=%0d want cnt=1 re=5 im=5",
                     bus.acc_cnt, bus.acc_re, bus.acc_im);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_cnt !== 4'd1 || bus.acc_re !== 20'd5) begin
            errors++;
            $display("FAIL bp_flush: got val=%0b cnt=%0d re=%0d want val=1 cnt=1 re=5",
                     bus.acc_val, bus.acc_cnt, bus.acc_re);
        end
        tick();
        bus.acc_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.acc_ready = 1'b0;
        send(1, -1);
        send(1, -1);
        bus.flush = 1'b1;
        tick();
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_re !== 20'd2 || bus.acc_im !== 20'(-2) ||
            bus.acc_cnt !== 4'd2) begin
            errors++;
            $display("FAIL flush_sum: got val=%0b re=%0d im=%0d cnt=%0d want val=1 re=2 im=-2 cnt=2",
                     bus.acc_val, bus.acc_re, $signed(bus.acc_im), bus.acc_cnt);
        end
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_cnt !== 4'd2 || bus.res_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_output: got val=%0b cnt=%0d rdy=%0b want val=1 cnt=2 rdy=0",
                     bus.acc_val, bus.acc_cnt, bus.res_ready);
        end
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        bus.flush = 1'b1;
        tick();
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.acc_val !== 1'b0 || bus.res_ready !== 1'b1 || bus.acc_cnt !== 4'd0) begin
            errors++;
            $display("FAIL flush_empty: got val=%0b rdy=%0b cnt=%0d want val=0 rdy=1 cnt=0",
                     bus.acc_val, bus.res_ready, bus.acc_cnt);
        end
        bus.flush = 1'b1;
        send(3, 4);
        bus.flush = 1'b0;
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_cnt !== 4'd1 || bus.acc_re !== 20'd3 ||
            bus.acc_im !== 20'd4) begin
            errors++;
            $display("FAIL flush_with_accept: got val=%0b cnt=%0d re=%0d im=%0d want val=1 cnt=1 re=3 im=4",
                     bus.acc_val, bus.acc_cnt, bus.acc_re, bus.acc_im);
        end
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
    endtask

    task automatic test_sw_rst();
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(7, -3);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        checks++;
        if (bus.acc_val !== 1'b0 || bus.res_ready !== 1'b0 || bus.acc_re !== 20'd0 ||
            bus.acc_im !== 20'd0 || bus.acc_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_accum: got val=%0b rdy=%0b re=%0d im=%0d cnt=%0d want all 0",
                     bus.acc_val, bus.res_ready, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        for (int i = 0; i < 4; i++) send(1, 2);
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_re !== 20'd4 || bus.acc_im !== 20'd8) begin
            errors++;
            $display("FAIL rst_pre_output: got val=%0b re=%0d im=%0d want val=1 re=4 im=8",
                     bus.acc_val, bus.acc_re, bus.acc_im);
        end
        sw_rst = 1'b1;
        bus.acc_ready = 1'b1;
        tick();
        sw_rst = 1'b0;
        bus.acc_ready = 1'b0;
        checks++;
        if (bus.acc_val !== 1'b0 || bus.res_ready !== 1'b0 || bus.acc_re !== 20'd0 ||
            bus.acc_im !== 20'd0 || bus.acc_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_in_output: got val=%0b rdy=%0b re=%0d im=%0d cnt=%0d want all 0",
                     bus.acc_val, bus.res_ready, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        for (int i = 0; i < 4; i++) send(2, 16);
        checks++;
        if (bus.acc_val !== 1'b1 || bus.acc_re !== 20'd8 || bus.acc_im !== 20'd64 ||
            bus.acc_cnt !== 4'd4) begin
            errors++;
            $display("FAIL rst_clean_run: got val=%0b re=%0d im=%0d cnt=%0d want val=1 re=8 im=64 cnt=4",
                     bus.acc_val, bus.acc_re, bus.acc_im, bus.acc_cnt);
        end
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        sw_rst        = 1'b1;
        bus.res_val   = 1'b0;
        bus.res_re    = '0;
        bus.res_im    = '0;
        bus.flush     = 1'b0;
        bus.acc_ready = 1'b0;
        test_reset();
        test_basic();
        test_corner();
        test_backpressure();
        test_flush();
        test_sw_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
